snell_div_sequencer: RTL and testbench
======================================

# snell_div_sequencer

Operand-preparation and control stage that sits directly upstream of `division_mod` in the Snell's-law datapath. It takes the incident-medium index `n1`, the refracted-medium index `n2` and `sin(theta1)`, and forms the numerator `n1*sin(theta1)` with a sequential shift-add multiplier. It then issues the division `n1*sin(theta1) / n2` to the divider, waits the divider latency, and packs the quotient into `sin(theta2)`. It also flags total internal reflection (TIR) and divide-by-zero.

## Interface
- `DIV_LAT`, 20: divider latency in cycles; the divider output is sampled `DIV_LAT`+1 rising edges after the operands are first driven.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `n1`  in  10  incident index, unsigned Q2.8.
- `n2`  in  10  refracted index, unsigned Q2.8.
- `sin_t1`  in  8  sin(theta1), unsigned Q0.8.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle result-valid pulse.
- `sin_t2`  out  8  sin(theta2), Q0.8; held until the next `done`.
- `tir`  out  1  total internal reflection; held until the next `done`.
- `err_div0`  out  1  `n2`==0; held until the next `done`.
- `div_inp1`  out  16  divider dividend.
- `div_inp2`  out  16  divider divisor.
- `div_oup`  in  16  divider integer quotient.
- `div_frac`  in  2  divider fractional quotient bits.
- `div_rfd`  in  1  divider ready-for-data.

## Operation
- **Reset values:** all outputs 0; state IDLE; counters 0.
- **Input capture:** on `start`=1 in IDLE, latch `n1`, `n2` and `sin_t1`. Later changes to these inputs are ignored until the next accepted `start`. A `start` asserted while `busy`=1 is ignored.
- **Divide-by-zero path:** if the latched `n2`==0, go IDLE→DONE with `err_div0`=1, `sin_t2`=0x00, `tir`=0. No divide is issued and `div_inp*` are unchanged.
- **MUL state (8 cycles):** shift-add over the `sin_t1` bits, LSB first, into an 18-bit accumulator. The exact product `n1*sin_t1` is in Q2.16.
- **ISSUE state:**
  - On entry, register `div_inp1` = `product[17:2]` (value `n1*s*2^14`) and `div_inp2` = {6'b0, `n2`}.
  - Both operands hold until the next ISSUE entry.
  - Stay in ISSUE while `div_rfd`=0.
  - When `div_rfd`=1, go to DIV_WAIT and load the counter with `DIV_LAT`-1.
- **DIV_WAIT state:** decrement the counter each cycle. At 0, capture `div_oup` and `div_frac` and go to DONE.
- **Result packing:** the quotient is `(n1*s/n2)*2^6`, carrying 2 fractional bits.
  - If `div_oup` >= 64: `tir`=1 and `sin_t2`=0xFF (saturated).
  - Otherwise: `tir`=0 and `sin_t2` = {`div_oup[5:0]`, `div_frac`}, truncated, no rounding.
  - `err_div0`=0 on this path.
- **DONE state (1 cycle):** `done`=1 and `busy`=1. The next state is always IDLE.
- **Output registering:** result outputs update on the edge that enters DONE and are stable while `done`=1.
- **Reset mid-operation:** return to IDLE immediately. No `done` is produced, and the result outputs clear to 0.

## Timing
- `start` sampled at edge 0. MUL occupies cycles 1–8 and ISSUE begins at cycle 9.
- With `div_rfd` held high: DIV_WAIT occupies cycles 10 to 9+`DIV_LAT`, and `done` is high in cycle `DIV_LAT`+10.
- Each cycle with `div_rfd`=0 in ISSUE adds exactly one cycle of latency.
- Divide-by-zero: `done` is high in cycle 1.
- Back-to-back operation: the earliest next accepted `start` is the cycle after `done`, since the FSM is back in IDLE by then. No pipelining; one request in flight at a time.

## Test plan
- **Basic divide:** `n1`=0x100, `n2`=0x180, `sin_t1`=0x80, `div_rfd`=1, `DIV_LAT`=20, paired with `division_mod` → `div_inp1`=0x2000, `div_inp2`=0x0180, `div_oup`=21, `div_frac`=1. Expect `done` at cycle 30 with `sin_t2`=0x55, `tir`=0, `err_div0`=0.
- **TIR:** `n1`=0x180, `n2`=0x100, `sin_t1`=0xC0 → `div_inp1`=0x4800, `div_oup`=72. Expect `tir`=1, `sin_t2`=0xFF.
- **Divide-by-zero:** `n2`=0 → `done` in cycle 1, `err_div0`=1, `sin_t2`=0, and `div_inp1`/`div_inp2` never change.
- **RFD stall:** hold `div_rfd`=0 for 5 cycles after ISSUE is entered → `done` moves to cycle 35, and `div_inp*` are stable throughout the stall.
- **Busy and back-to-back:** pulse `start` at cycle 4 of a running request → ignored, with a single `done`. A new `start` in the cycle after `done` is accepted, and its result matches a standalone run.
- **Mid-operation reset:** assert `rst` during DIV_WAIT → `busy`=0 and all outputs 0 asynchronously, with no `done` pulse after release. A fresh request then completes normally.

Source files
------------

// File: rtl/snell_div_sequencer.sv
// Operand prep and control ahead of division_mod: shift-add n1*sin_t1, issue the divide, pack sin(theta2).
// Latency DIV_LAT+10 cycles (1 for n2==0); stalls in ISSUE while div_rfd=0; start is ignored while busy.
module snell_div_sequencer #(
  parameter int DIV_LAT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  n1,
  input  logic [9:0]  n2,
  input  logic [7:0]  sin_t1,
  output logic        busy,
  output logic        done,
  output logic [7:0]  sin_t2,
  output logic        tir,
  output logic        err_div0,
  output logic [15:0] div_inp1,
  output logic [15:0] div_inp2,
  input  logic [15:0] div_oup,
  input  logic [1:0]  div_frac,
  input  logic        div_rfd
);

  localparam int CW = $clog2(DIV_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    n1_q, n1_d;
  logic [9:0]    n2_q, n2_d;
  logic [7:0]    s_q, s_d;
  logic [17:0]   acc_q, acc_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    sin_t2_q, sin_t2_d;
  logic          tir_q, tir_d;
  logic          err_q, err_d;
  logic [15:0]   inp1_q, inp1_d;
  logic [15:0]   inp2_q, inp2_d;
  logic [17:0]   addend;
  logic [17:0]   acc_sum;

  always_comb begin
    state_d  = state_q;
    n1_d     = n1_q;
    n2_d     = n2_q;
    s_d      = s_q;
    acc_d    = acc_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    sin_t2_d = sin_t2_q;
    tir_d    = tir_q;
    err_d    = err_q;
    inp1_d   = inp1_q;
    inp2_d   = inp2_q;

    addend  = s_q[bit_q] ? ({8'b0, n1_q} << bit_q) : 18'd0;
    acc_sum = acc_q + addend;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n1_d  = n1;
          n2_d  = n2;
          s_d   = sin_t1;
          acc_d = '0;
          bit_d = '0;
          if (n2 == 10'd0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            sin_t2_d = 8'h00;
            tir_d    = 1'b0;
            err_d    = 1'b1;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_sum;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          // Q2.16 product scaled down to the 16-bit dividend: value n1*s*2^14
          state_d = S_ISSUE;
          inp1_d  = acc_sum[17:2];
          inp2_d  = {6'b0, n2_q};
        end
      end
      S_ISSUE: begin
        if (div_rfd) begin
          state_d = S_WAIT;
          cnt_d   = CW'(DIV_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
          if (div_oup >= 16'd64) begin
            tir_d    = 1'b1;
            sin_t2_d = 8'hFF;
          end else begin
            tir_d    = 1'b0;
            sin_t2_d = {div_oup[5:0], div_frac};
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n1_q     <= '0;
      n2_q     <= '0;
      s_q      <= '0;
      acc_q    <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sin_t2_q <= '0;
      tir_q    <= 1'b0;
      err_q    <= 1'b0;
      inp1_q   <= '0;
      inp2_q   <= '0;
    end else begin
      state_q  <= state_d;
      n1_q     <= n1_d;
      n2_q     <= n2_d;
      s_q      <= s_d;
      acc_q    <= acc_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sin_t2_q <= sin_t2_d;
      tir_q    <= tir_d;
      err_q    <= err_d;
      inp1_q   <= inp1_d;
      inp2_q   <= inp2_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sin_t2   = sin_t2_q;
  assign tir      = tir_q;
  assign err_div0 = err_q;
  assign div_inp1 = inp1_q;
  assign div_inp2 = inp2_q;

endmodule

// File: tb/tb_snell_div_sequencer.sv
// Directed bench for snell_div_sequencer with a behavioural divider attached to div_inp*/div_oup.
module tb_snell_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  n1 = '0;
  logic [9:0]  n2 = '0;
  logic [7:0]  sin_t1 = '0;
  logic        busy, done, tir, err_div0;
  logic [7:0]  sin_t2;
  logic [15:0] div_inp1, div_inp2;
  logic [15:0] div_oup;
  logic [1:0]  div_frac;
  logic        div_rfd = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_at;

  snell_div_sequencer #(.DIV_LAT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .n1(n1), .n2(n2), .sin_t1(sin_t1),
    .busy(busy), .done(done), .sin_t2(sin_t2), .tir(tir), .err_div0(err_div0),
    .div_inp1(div_inp1), .div_inp2(div_inp2), .div_oup(div_oup),
    .div_frac(div_frac), .div_rfd(div_rfd)
  );

  always #5 clk = ~clk;

  // Ideal divider: integer quotient plus two fractional bits, truncated.
  always_comb begin
    int a, b;
    a = int'(div_inp1);
    b = int'(div_inp2);
    div_oup  = '0;
    div_frac = '0;
    if (b != 0) begin
      div_oup  = 16'(a / b);
      div_frac = 2'(((a % b) * 4) / b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
  endtask

  task automatic launch(input logic [9:0] a, input logic [9:0] b, input logic [7:0] s);
    n1 = a;
    n2 = b;
    sin_t1 = s;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(output int at);
    at = -1;
    for (int k = 0; k < 200 && at < 0; k++) begin
      if (done) at = cyc;
      else step();
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sin_t2", sin_t2, 0);
    chk("rst_tir", tir, 0);
    chk("rst_err", err_div0, 0);
    chk("rst_inp1", div_inp1, 0);
    chk("rst_inp2", div_inp2, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Basic divide; inputs scrambled after capture must not matter
    launch(10'h100, 10'h180, 8'h80);
    n1 = 10'h3FF; n2 = 10'h001; sin_t1 = 8'h01;
    chk("basic_busy_c1", busy, 1);
    run_to_done(done_at);
    chk("basic_done_cycle", done_at, 30);
    chk("basic_inp1", div_inp1, 16'h2000);
    chk("basic_inp2", div_inp2, 16'h0180);
    chk("basic_sin_t2", sin_t2, 8'h55);
    chk("basic_tir", tir, 0);
    chk("basic_err", err_div0, 0);
    chk("basic_busy_done", busy, 1);
    step();
    chk("basic_done_pulse", done, 0);
    chk("basic_idle_busy", busy, 0);
    chk("basic_hold_sin", sin_t2, 8'h55);

    // Divide-by-zero
    launch(10'h100, 10'h000, 8'h80);
    run_to_done(done_at);
    chk("div0_done_cycle", done_at, 1);
    chk("div0_err", err_div0, 1);
    chk("div0_sin_t2", sin_t2, 0);
    chk("div0_tir", tir, 0);
    chk("div0_inp1_kept", div_inp1, 16'h2000);
    chk("div0_inp2_kept", div_inp2, 16'h0180);
    step();

    // Total internal reflection
    launch(10'h180, 10'h100, 8'hC0);
    run_to_done(done_at);
    chk("tir_done_cycle", done_at, 30);
    chk("tir_inp1", div_inp1, 16'h4800);
    chk("tir_flag", tir, 1);
    chk("tir_sin_t2", sin_t2, 8'hFF);
    chk("tir_err_cleared", err_div0, 0);
    step();

    // Quotient 63: largest non-TIR value
    launch(10'h100, 10'h100, 8'hFF);
    run_to_done(done_at);
    chk("q63_inp1", div_inp1, 16'h3FC0);
    chk("q63_tir", tir, 0);
    chk("q63_sin_t2", sin_t2, 8'hFF);
    step();

    // Quotient exactly 64: smallest TIR value
    launch(10'h200, 10'h100, 8'h80);
    run_to_done(done_at);
    chk("q64_inp1", div_inp1, 16'h4000);
    chk("q64_tir", tir, 1);
    chk("q64_sin_t2", sin_t2, 8'hFF);
    step();

    // div_rfd low for the first 5 ISSUE cycles
    div_rfd = 1'b0;
    launch(10'h0C0, 10'h100, 8'hFF);
    while (cyc < 9) step();
    chk("stall_inp1_c9", div_inp1, 16'h2FD0);
    chk("stall_inp2_c9", div_inp2, 16'h0100);
    while (cyc < 13) step();
    chk("stall_inp1_c13", div_inp1, 16'h2FD0);
    chk("stall_inp2_c13", div_inp2, 16'h0100);
    chk("stall_busy_c13", busy, 1);
    step();
    div_rfd = 1'b1;
    run_to_done(done_at);
    chk("stall_done_cycle", done_at, 35);
    chk("stall_sin_t2", sin_t2, 8'hBF);
    chk("stall_tir", tir, 0);
    step();

    // Start while busy is ignored; back-to-back start right after done
    done_cnt = 0;
    launch(10'h100, 10'h180, 8'h80);
    while (cyc < 4) step();
    n1 = 10'h200; n2 = 10'h000; sin_t1 = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done(done_at);
    chk("b2b_first_cycle", done_at, 30);
    chk("b2b_first_sin", sin_t2, 8'h55);
    chk("b2b_first_err", err_div0, 0);
    step();
    launch(10'h180, 10'h100, 8'hC0);
    run_to_done(done_at);
    chk("b2b_second_cycle", done_at, 30);
    chk("b2b_second_tir", tir, 1);
    chk("b2b_second_sin", sin_t2, 8'hFF);
    repeat (5) step();
    chk("b2b_done_count", done_cnt, 2);

    // Asynchronous reset during DIV_WAIT
    launch(10'h100, 10'h180, 8'h80);
    while (cyc < 15) step();
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_sin_t2", sin_t2, 0);
    chk("mrst_tir", tir, 0);
    chk("mrst_err", err_div0, 0);
    chk("mrst_inp1", div_inp1, 0);
    chk("mrst_inp2", div_inp2, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_cnt = 0;
    repeat (40) step();
    chk("mrst_no_done", done_cnt, 0);
    chk("mrst_idle", busy, 0);
    launch(10'h100, 10'h180, 8'h80);
    run_to_done(done_at);
    chk("mrst_fresh_cycle", done_at, 30);
    chk("mrst_fresh_sin", sin_t2, 8'h55);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
